// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bundle between the memory stage (master)
// and the data memory (slave).
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: branch/jump redirect, byte/half/word loads and stores
// over a req/ack data memory, and the registered MEM/WB bundle.
module mem_stage #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [169:0]   EX_MEM_out,
  output logic           pc_src,
  output logic [31:0]    pc_target,
  output logic           mem_stall,
  output logic           mem_err,
  output logic [103:0]   MEM_WB_out,
  mem_stage_if.master    dmem
);

  typedef enum logic {IDLE, WAIT} state_e;

  logic [1:0]  ls_bit;
  logic [1:0]  branch;
  logic        mem_to_reg;
  logic        mem_write;
  logic        reg_write;
  logic        jump;
  logic        ext_op;
  logic        pc_to_reg;
  logic [31:0] branch_target;
  logic        zero;
  logic [31:0] pc_add_out;
  logic [25:0] instr26;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic [4:0]  wreg;

  assign ls_bit        = EX_MEM_out[1:0];
  assign branch        = EX_MEM_out[3:2];
  assign mem_to_reg    = EX_MEM_out[4];
  assign mem_write     = EX_MEM_out[5];
  assign reg_write     = EX_MEM_out[6];
  assign jump          = EX_MEM_out[7];
  assign ext_op        = EX_MEM_out[8];
  assign pc_to_reg     = EX_MEM_out[9];
  assign branch_target = EX_MEM_out[41:10];
  assign zero          = EX_MEM_out[42];
  assign pc_add_out    = EX_MEM_out[74:43];
  assign instr26       = EX_MEM_out[100:75];
  assign alu_out       = EX_MEM_out[132:101];
  assign store_data    = EX_MEM_out[164:133];
  assign wreg          = EX_MEM_out[169:165];

  state_e       state_q, state_d;
  logic         req_q, req_d;
  logic         we_q, we_d;
  logic [31:0]  addr_q, addr_d;
  logic [3:0]   be_q, be_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         err_q, err_d;
  logic [103:0] wb_q, wb_d;

  logic memop;
  logic misaligned;
  logic aligned_op;
  logic timeout;

  function automatic logic [31:0] fmt_load(input logic [31:0] rd, input logic [1:0] lane,
                                           input logic [1:0] ls, input logic ext);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lane[1] ? rd[31:16] : rd[15:0];
    case (ls)
      2'b10:   fmt_load = {{24{ext & b[7]}}, b};
      2'b01:   fmt_load = {{16{ext & h[15]}}, h};
      default: fmt_load = rd;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] lane, input logic [1:0] ls);
    case (ls)
      2'b10:   lane_be = 4'b0001 << lane;
      2'b01:   lane_be = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [31:0] sd, input logic [1:0] ls);
    case (ls)
      2'b10:   lane_wdata = {4{sd[7:0]}};
      2'b01:   lane_wdata = {2{sd[15:0]}};
      default: lane_wdata = sd;
    endcase
  endfunction

  function automatic logic [103:0] wb_pack(input logic [31:0] load_data, input logic rw);
    wb_pack = {pc_to_reg, mem_to_reg, rw, pc_add_out, load_data, alu_out, wreg};
  endfunction

  // Half accesses need an even address; word accesses (LS 00 or 11) need word alignment.
  assign memop      = mem_to_reg | mem_write;
  assign misaligned = memop & (((ls_bit == 2'b01) & alu_out[0]) |
                               (((ls_bit == 2'b00) | (ls_bit == 2'b11)) & (alu_out[1:0] != 2'b00)));
  assign aligned_op = memop & ~misaligned;
  assign timeout    = (cnt_q == 8'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    wb_d      = wb_q;
    mem_stall = 1'b0;
    pc_src    = 1'b0;
    pc_target = 32'h0;
    case (state_q)
      IDLE: begin
        if (jump) begin
          pc_src    = 1'b1;
          pc_target = {pc_add_out[31:28], instr26, 2'b00};
        end else if (((branch == 2'b01) & zero) | ((branch == 2'b10) & ~zero)) begin
          pc_src    = 1'b1;
          pc_target = branch_target;
        end
        if (aligned_op) begin
          mem_stall = 1'b1;
          state_d   = WAIT;
          req_d     = 1'b1;
          we_d      = mem_write;
          addr_d    = {alu_out[31:2], 2'b00};
          be_d      = lane_be(alu_out[1:0], ls_bit);
          wdata_d   = lane_wdata(store_data, ls_bit);
          cnt_d     = 8'd0;
        end else begin
          wb_d = wb_pack(32'h0, reg_write & ~misaligned);
          if (misaligned) err_d = 1'b1;
        end
      end
      WAIT: begin
        // EX/MEM is held stable while stalled, so live fields still describe this access.
        if (dmem.dmem_ack) begin
          wb_d    = wb_pack(mem_write ? 32'h0 : fmt_load(dmem.dmem_rdata, alu_out[1:0], ls_bit, ext_op),
                            reg_write);
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (timeout) begin
          wb_d    = wb_pack(32'h0, 1'b0);
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d     = cnt_q + 8'd1;
          mem_stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      wb_q    <= 104'h0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wb_q    <= wb_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;
  assign mem_err         = err_q;
  assign MEM_WB_out      = wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random and directed EX/MEM bundles against
// an arithmetic reference model, with a responding data memory.
module tb_mem_stage;
  localparam int TMO = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [169:0] ex_mem = '0;
  logic         pc_src;
  logic [31:0]  pc_target;
  logic         mem_stall;
  logic         mem_err;
  logic [103:0] mem_wb;

  mem_stage_if dif ();

  mem_stage #(.MEM_TIMEOUT(TMO)) dut (
    .clock(clk), .reset(rst), .EX_MEM_out(ex_mem), .pc_src(pc_src), .pc_target(pc_target),
    .mem_stall(mem_stall), .mem_err(mem_err), .MEM_WB_out(mem_wb), .dmem(dif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ls, br;
    logic m2r, mw, rw, jmp, ext, p2r, zero;
    logic [31:0] bt, pc, alu, sd, rdata;
    logic [25:0] i26;
    logic [4:0] wreg;
    int dly;  // ack in the dly-th request cycle; 0 means never
  } instr_t;

  typedef struct { logic [103:0] wb; logic err; } sb_t;
  typedef struct { logic [31:0] addr, wdata, rdata; logic we; logic [3:0] be; int dly; } rq_t;

  sb_t sbq[$];
  rq_t rqq[$];
  int  total = 0;
  int  bad = 0;
  logic tx_live = 1'b0;
  logic err_model = 1'b0;

  task automatic chk(input string nm, input logic [103:0] act, input logic [103:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [169:0] pack(input instr_t t);
    pack = {t.wreg, t.sd, t.alu, t.i26, t.pc, t.zero, t.bt, t.p2r, t.ext, t.jmp, t.rw, t.mw, t.m2r, t.br, t.ls};
  endfunction

  // Byte count of the access: 1, 2 or 4.
  function automatic int size_of(input logic [1:0] ls);
    size_of = (ls == 2'b10) ? 1 : (ls == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a, input logic [1:0] ls, input logic ext);
    longint v;
    int sz;
    sz = size_of(ls);
    if (sz == 4) return rd;
    v = (longint'(rd) >> (8 * ((a % 4) / sz * sz))) % (longint'(1) << (8 * sz));
    if (ext && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
    return 32'(v);
  endfunction

  task automatic issue(input instr_t t);
    logic memop, mis, to, exp_src;
    logic [31:0] exp_tgt, ld;
    int sz, exp_stall, stall_cnt;
    bit done;
    rq_t r;
    sb_t e;
    memop = t.m2r | t.mw;
    sz = size_of(t.ls);
    mis = memop && (t.alu % sz != 0);
    to = memop && !mis && (t.dly == 0 || t.dly > TMO);
    exp_src = t.jmp || (t.br == 2'b01 && t.zero) || (t.br == 2'b10 && !t.zero);
    exp_tgt = t.jmp ? ((t.pc & 32'hF000_0000) | (32'(t.i26) * 4)) : t.bt;
    ld = (memop && !mis && !to && !t.mw) ? model_load(t.rdata, t.alu, t.ls, t.ext) : 32'h0;
    if (mis || to) err_model = 1'b1;
    e.wb = {t.p2r, t.m2r, t.rw & !mis & !to, t.pc, ld, t.alu, t.wreg};
    e.err = err_model;
    exp_stall = (!memop || mis) ? 0 : (to ? TMO : t.dly);
    @(posedge clk); #1;
    ex_mem = pack(t);
    tx_live = 1'b1;
    sbq.push_back(e);
    if (memop && !mis) begin
      r.addr = t.alu & 32'hFFFF_FFFC; r.we = t.mw; r.rdata = t.rdata; r.dly = t.dly;
      r.be = (sz == 1) ? 4'(1 << (t.alu % 4)) : (sz == 2) ? 4'(3 << (t.alu % 4)) : 4'hF;
      r.wdata = (sz == 1) ? (t.sd % 256) * 32'h0101_0101 : (sz == 2) ? (t.sd % 65536) * 32'h0001_0001 : t.sd;
      rqq.push_back(r);
    end
    stall_cnt = 0;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("pc_src", 104'(pc_src), 104'(exp_src));
        if (exp_src) chk("pc_target", 104'(pc_target), 104'(exp_tgt));
      end else begin
        chk("pc_src_wait", 104'(pc_src), 104'(0));
      end
      if (!mem_stall) done = 1;
      else stall_cnt++;
    end
    if (!done) begin
      bad++; total++;
      $display("FAIL stall_bound got=stuck want=released t=%0t", $time);
    end else begin
      chk("stall_cycles", 104'(stall_cnt), 104'(exp_stall));
    end
  endtask

  function automatic instr_t nop();
    instr_t t;
    t.ls = 0; t.br = 0; t.m2r = 0; t.mw = 0; t.rw = 0; t.jmp = 0; t.ext = 0; t.p2r = 0; t.zero = 0;
    t.bt = 0; t.pc = 0; t.alu = 0; t.sd = 0; t.rdata = 0; t.i26 = 0; t.wreg = 0; t.dly = 1;
    return t;
  endfunction

  function automatic instr_t rnd();
    instr_t t;
    int mode;
    mode = $urandom_range(0, 2);
    t.ls = 2'($urandom); t.br = 2'($urandom); t.rw = 1'($urandom); t.jmp = ($urandom_range(0, 3) == 0);
    t.ext = 1'($urandom); t.p2r = 1'($urandom); t.zero = 1'($urandom);
    t.bt = $urandom; t.pc = $urandom; t.alu = $urandom; t.sd = $urandom; t.rdata = $urandom;
    t.i26 = 26'($urandom); t.wreg = 5'($urandom);
    t.m2r = (mode == 1) || (mode == 2 && $urandom_range(0, 3) == 0);
    t.mw = (mode == 2);
    if ($urandom_range(0, 1) == 1) t.alu = t.alu & 32'hFFFF_FFFC;
    t.dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
    return t;
  endfunction

  // Scoreboard monitor: MEM/WB and mem_err are checked after each edge that accepted a bundle.
  initial begin
    bit pend = 0;
    sb_t e;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (sbq.size() == 0) begin
          bad++; total++;
          $display("FAIL sb_empty got=write want=none t=%0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("mem_wb", mem_wb, e.wb);
          chk("mem_err", 104'(mem_err), 104'(e.err));
        end
      end
      pend = tx_live && !mem_stall && !rst;
    end
  end

  // Data memory responder: checks each request once and acks after its planned delay.
  initial begin
    bit busy = 0;
    int cyc = 0;
    rq_t cur;
    dif.dmem_ack = 1'b0;
    dif.dmem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      dif.dmem_ack = 1'b0;
      dif.dmem_rdata = $urandom;
      if (rst) begin
        busy = 0;
      end else if (dif.dmem_req) begin
        if (!busy) begin
          busy = 1; cyc = 0;
          if (rqq.size() == 0) begin
            bad++; total++;
            $display("FAIL req_unexpected got=req want=none t=%0t", $time);
            cur.dly = 1; cur.addr = dif.dmem_addr; cur.we = dif.dmem_we; cur.rdata = 0;
            cur.be = dif.dmem_be; cur.wdata = dif.dmem_wdata;
          end else begin
            cur = rqq.pop_front();
          end
          chk("dmem_addr", 104'(dif.dmem_addr), 104'(cur.addr));
          chk("dmem_we", 104'(dif.dmem_we), 104'(cur.we));
          if (cur.we) begin
            chk("dmem_be", 104'(dif.dmem_be), 104'(cur.be));
            chk("dmem_wdata", 104'(dif.dmem_wdata), 104'(cur.wdata));
          end
        end
        cyc++;
        if (cur.dly == cyc) begin
          dif.dmem_ack = 1'b1;
          dif.dmem_rdata = cur.rdata;
        end
      end else if (busy) begin
        busy = 0;
        chk("req_cycles", 104'(cyc), 104'((cur.dly == 0 || cur.dly > TMO) ? TMO : cur.dly));
      end
    end
  end

  initial begin
    instr_t t;
    rq_t r;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wb", mem_wb, 104'h0);
    chk("rst_req", 104'(dif.dmem_req), 104'(0));
    chk("rst_outs", 104'({mem_err, mem_stall, pc_src, pc_target, dif.dmem_we, dif.dmem_be, dif.dmem_addr, dif.dmem_wdata}), 104'h0);
    @(posedge clk); #1 rst = 1'b0;

    t = nop(); t.alu = 32'h1234; t.rw = 1; t.wreg = 5; issue(t);
    t = nop(); t.ls = 2'b10; t.m2r = 1; t.rw = 1; t.ext = 1; t.alu = 32'h103; t.rdata = 32'h80FF_FF00; t.dly = 2; issue(t);
    t = nop(); t.ls = 2'b01; t.mw = 1; t.alu = 32'h102; t.sd = 32'h0000_ABCD; t.dly = 3; issue(t);
    t = nop(); t.br = 2'b01; t.zero = 1; t.bt = 32'h40; issue(t);
    t.jmp = 1; t.pc = 32'hA000_0000; t.i26 = 26'h123_4567; issue(t);
    t = nop(); t.br = 2'b11; t.zero = 1; t.bt = 32'h80; issue(t);
    t = nop(); t.m2r = 1; t.rw = 1; t.alu = 32'h101; issue(t);
    t = nop(); t.m2r = 1; t.rw = 1; t.alu = 32'h200; t.dly = 0; issue(t);
    for (int i = 0; i < 150; i++) issue(rnd());

    // Reset in the middle of an outstanding access.
    @(posedge clk); #1;
    tx_live = 1'b0;
    t = nop(); t.m2r = 1; t.rw = 1; t.alu = 32'h300; t.dly = 0;
    ex_mem = pack(t);
    r.addr = 32'h300; r.we = 0; r.be = 4'hF; r.wdata = 0; r.rdata = 0; r.dly = 0;
    rqq.push_back(r);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("wait_req", 104'(dif.dmem_req), 104'(1));
    chk("wait_stall", 104'(mem_stall), 104'(1));
    chk("wait_err", 104'(mem_err), 104'(err_model));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 ex_mem = '0;
    @(negedge clk);
    chk("midrst_req", 104'(dif.dmem_req), 104'(0));
    chk("midrst_err", 104'(mem_err), 104'(0));
    chk("midrst_wb", mem_wb, 104'h0);
    chk("midrst_stall", 104'(mem_stall), 104'(0));
    @(posedge clk); #1 rst = 1'b0;
    err_model = 1'b0;
    for (int i = 0; i < 20; i++) issue(rnd());
    @(posedge clk); #1 tx_live = 1'b0;

    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
    chk("sb_drain", 104'(sbq.size()), 104'(0));
    chk("rq_drain", 104'(rqq.size()), 104'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
